uart_packet_rx: RTL and testbench

Downstream framing stage for the UART receiver; consumes its one-cycle byte strobe and data byte.
Hunts for a sync byte, then parses a length, a payload and a checksum, buffering the payload internally.
Releases the payload only when the checksum is good, as a valid/ready byte stream with an end marker.
Flags length, checksum and inter-byte timeout errors.

---
 rtl/uart_packet_rx.sv | 147 ++++++++++++++
 tb/tb_uart_packet_rx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: sync-hunting frame parser that buffers a payload and releases it as a valid/ready stream only when its checksum is good
module uart_packet_rx #(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 21700
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_busy,
  output logic       o_err_len,
  output logic       o_err_checksum,
  output logic       o_err_timeout,
  output logic       o_drop
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] len_q, len_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rd_nxt;
  logic [7:0] sum_q, sum_d, data_q, data_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic err_len_q, err_len_d, err_ck_q, err_ck_d, err_to_q, err_to_d, drop_q, drop_d;
  logic in_frame, timeout;
  // Power-of-two depth keeps the LW-bit indices exactly matched to the array
  logic [7:0] mem_q [2**LW];
  always_comb begin
    in_frame = state_q inside {LEN, PAYLOAD, CHECK};
    timeout = in_frame && !i_rx_dv && tcnt_q >= TW'(TIMEOUT_CLKS - 1);
    rd_nxt = rd_idx_q + 1'b1;
    state_d = state_q;
    len_d = len_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    sum_d = sum_q;
    data_d = data_q;
    valid_d = valid_q;
    last_d = last_q;
    err_len_d = 1'b0;
    err_ck_d = 1'b0;
    err_to_d = 1'b0;
    drop_d = 1'b0;
    case (state_q)
      HUNT: if (i_rx_dv && i_rx_byte == SYNC_BYTE) state_d = LEN;
      LEN: if (i_rx_dv) begin
        if (i_rx_byte == 8'd0 || i_rx_byte > 8'(MAX_LEN)) begin
          err_len_d = 1'b1;
          state_d = HUNT;
        end else begin
          len_d = i_rx_byte[LW-1:0];
          sum_d = i_rx_byte;
          wr_idx_d = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (i_rx_dv) begin
        sum_d = sum_q + i_rx_byte;
        wr_idx_d = wr_idx_q + 1'b1;
        state_d = (wr_idx_q == LW'(len_q - 1'b1)) ? CHECK : PAYLOAD;
      end
      CHECK: if (i_rx_dv) begin
        if (8'(sum_q + i_rx_byte) == 8'd0) begin
          state_d = DRAIN;
          rd_idx_d = '0;
          valid_d = 1'b1;
          data_d = mem_q[LW'(0)];
          last_d = len_q == LW'(1);
        end else begin
          err_ck_d = 1'b1;
          state_d = HUNT;
        end
      end
      DRAIN: begin
        drop_d = i_rx_dv;
        if (valid_q && i_ready) begin
          if (last_q) begin
            state_d = HUNT;
            valid_d = 1'b0;
            last_d = 1'b0;
          end else begin
            rd_idx_d = rd_nxt;
            data_d = mem_q[rd_nxt];
            last_d = rd_nxt == LW'(len_q - 1'b1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (timeout) begin
      state_d = HUNT;
      err_to_d = 1'b1;
    end
    tcnt_d = (!in_frame || i_rx_dv || state_d != state_q) ? '0 :
             (tcnt_q == TW'(TIMEOUT_CLKS)) ? tcnt_q : tcnt_q + 1'b1;
    busy_d = state_d != HUNT;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= HUNT;
      len_q <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      sum_q <= '0;
      tcnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      err_len_q <= 1'b0;
      err_ck_q <= 1'b0;
      err_to_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      sum_q <= sum_d;
      tcnt_q <= tcnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      busy_q <= busy_d;
      err_len_q <= err_len_d;
      err_ck_q <= err_ck_d;
      err_to_q <= err_to_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (state_q == PAYLOAD && i_rx_dv) mem_q[wr_idx_q] <= i_rx_byte;
  end
  assign o_data = data_q;
  assign o_valid = valid_q;
  assign o_last = last_q;
  assign o_busy = busy_q;
  assign o_err_len = err_len_q;
  assign o_err_checksum = err_ck_q;
  assign o_err_timeout = err_to_q;
  assign o_drop = drop_q;
endmodule

// File: tb/tb_uart_packet_rx.sv
// tb_uart_packet_rx: directed scenario tests for uart_packet_rx with hand-computed expectations
module tb_uart_packet_rx;
  localparam int T = 30;
  logic i_clk = 1'b0, i_reset = 1'b1, i_rx_dv = 1'b0, i_ready = 1'b1;
  logic [7:0] i_rx_byte = 8'h00;
  logic [7:0] o_data;
  logic o_valid, o_last, o_busy, o_err_len, o_err_checksum, o_err_timeout, o_drop;
  int vecs = 0, errs = 0;

  uart_packet_rx #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_busy(o_busy), .o_err_len(o_err_len), .o_err_checksum(o_err_checksum),
    .o_err_timeout(o_err_timeout), .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_dv = 1'b1;
    i_rx_byte = b;
    tick();
    i_rx_dv = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    vecs++;
    if ({o_valid, o_last, o_busy, o_err_len, o_err_checksum, o_err_timeout, o_drop, o_data} !== 15'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %b want 0", {o_valid, o_last, o_busy, o_err_len, o_err_checksum, o_err_timeout, o_drop, o_data});
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_good;
    logic [7:0] e [3];
    e = '{8'h11, 8'h22, 8'h33};
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    vecs++;
    if ({o_busy, o_valid} !== 2'b10) begin
      errs++;
      $display("FAIL good_pre_ck: busy,valid got %b want 10", {o_busy, o_valid});
    end
    send(8'h97);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if ({o_valid, o_last, o_data} !== {1'b1, i == 2, e[i]}) begin
        errs++;
        $display("FAIL good_beat%0d: valid,last,data got %b,%b,%h want 1,%b,%h", i, o_valid, o_last, o_data, i == 2, e[i]);
      end
      vecs++;
      if ({o_err_len, o_err_checksum, o_err_timeout, o_drop} !== 4'b0) begin
        errs++;
        $display("FAIL good_noerr%0d: got %b want 0000", i, {o_err_len, o_err_checksum, o_err_timeout, o_drop});
      end
      tick();
    end
    vecs++;
    if ({o_valid, o_busy} !== 2'b00) begin
      errs++;
      $display("FAIL good_end: valid,busy got %b want 00", {o_valid, o_busy});
    end
  endtask

  task automatic test_bad_checksum;
    logic [7:0] e [3];
    e = '{8'h11, 8'h22, 8'h33};
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
    vecs++;
    if ({o_err_checksum, o_valid, o_busy} !== 3'b100) begin
      errs++;
      $display("FAIL ck_pulse: err,valid,busy got %b want 100", {o_err_checksum, o_valid, o_busy});
    end
    tick();
    vecs++;
    if ({o_err_checksum, o_valid} !== 2'b00) begin
      errs++;
      $display("FAIL ck_after: err,valid got %b want 00", {o_err_checksum, o_valid});
    end
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if ({o_valid, o_last, o_data} !== {1'b1, i == 2, e[i]}) begin
        errs++;
        $display("FAIL ck_recover%0d: valid,last,data got %b,%b,%h want 1,%b,%h", i, o_valid, o_last, o_data, i == 2, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_length;
    send(8'hA5); send(8'h00);
    vecs++;
    if ({o_err_len, o_busy} !== 2'b10) begin
      errs++;
      $display("FAIL len_zero: err,busy got %b want 10", {o_err_len, o_busy});
    end
    tick();
    vecs++;
    if (o_err_len !== 1'b0) begin
      errs++;
      $display("FAIL len_zero_once: got %b want 0", o_err_len);
    end
    send(8'hA5); send(8'h11);
    vecs++;
    if ({o_err_len, o_busy} !== 2'b10) begin
      errs++;
      $display("FAIL len_big: err,busy got %b want 10", {o_err_len, o_busy});
    end
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h78);
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if ({o_valid, o_last, o_data} !== {1'b1, i == 15, 8'(i)}) begin
        errs++;
        $display("FAIL len_max_beat%0d: valid,last,data got %b,%b,%h want 1,%b,%h", i, o_valid, o_last, o_data, i == 15, 8'(i));
      end
      tick();
    end
    vecs++;
    if (o_valid !== 1'b0) begin
      errs++;
      $display("FAIL len_max_end: valid got %b want 0", o_valid);
    end
  endtask

  task automatic test_hunt;
    logic [7:0] e [2];
    e = '{8'hA5, 8'h01};
    send(8'h00); send(8'hFF); send(8'h5A);
    vecs++;
    if ({o_busy, o_err_len, o_err_checksum} !== 3'b000) begin
      errs++;
      $display("FAIL hunt_ignore: busy,errs got %b want 000", {o_busy, o_err_len, o_err_checksum});
    end
    send(8'hA5); send(8'h02); send(8'hA5); send(8'h01); send(8'h58);
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if ({o_valid, o_last, o_data} !== {1'b1, i == 1, e[i]}) begin
        errs++;
        $display("FAIL hunt_beat%0d: valid,last,data got %b,%b,%h want 1,%b,%h", i, o_valid, o_last, o_data, i == 1, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
    vecs++;
    if ({o_valid, o_data} !== {1'b1, 8'h11}) begin
      errs++;
      $display("FAIL bp_first: valid,data got %b,%h want 1,11", o_valid, o_data);
    end
    tick();
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if ({o_valid, o_last, o_data} !== {2'b10, 8'h22}) begin
        errs++;
        $display("FAIL bp_hold%0d: valid,last,data got %b,%b,%h want 1,0,22", i, o_valid, o_last, o_data);
      end
      if (i == 2) begin
        send(8'h42);
        vecs++;
        if (o_drop !== 1'b1) begin
          errs++;
          $display("FAIL bp_drop: got %b want 1", o_drop);
        end
      end else begin
        tick();
      end
    end
    vecs++;
    if ({o_drop, o_valid, o_data} !== {2'b01, 8'h22}) begin
      errs++;
      $display("FAIL bp_release: drop,valid,data got %b,%b,%h want 0,1,22", o_drop, o_valid, o_data);
    end
    i_ready = 1'b1;
    tick();
    vecs++;
    if ({o_valid, o_last, o_data} !== {2'b11, 8'h33}) begin
      errs++;
      $display("FAIL bp_last: valid,last,data got %b,%b,%h want 1,1,33", o_valid, o_last, o_data);
    end
    tick();
    vecs++;
    if ({o_valid, o_busy} !== 2'b00) begin
      errs++;
      $display("FAIL bp_end: valid,busy got %b want 00", {o_valid, o_busy});
    end
  endtask

  task automatic test_timeout;
    int early = 0;
    send(8'hA5); send(8'h02); send(8'h11);
    for (int k = 1; k <= T; k++) begin
      if (o_err_timeout !== 1'b0 || o_busy !== 1'b1) early++;
      tick();
    end
    vecs++;
    if (early != 0) begin
      errs++;
      $display("FAIL to_early: %0d cycles with timeout/idle want 0", early);
    end
    vecs++;
    if ({o_err_timeout, o_busy} !== 2'b10) begin
      errs++;
      $display("FAIL to_pulse: err,busy got %b want 10", {o_err_timeout, o_busy});
    end
    tick();
    vecs++;
    if (o_err_timeout !== 1'b0) begin
      errs++;
      $display("FAIL to_once: got %b want 0", o_err_timeout);
    end
    send(8'hA5); send(8'h02); send(8'h11);
    repeat (T - 1) tick();
    send(8'h22);
    vecs++;
    if ({o_err_timeout, o_busy} !== 2'b01) begin
      errs++;
      $display("FAIL to_byte_wins: err,busy got %b want 01", {o_err_timeout, o_busy});
    end
    send(8'hCB);
    vecs++;
    if ({o_valid, o_last, o_data} !== {2'b10, 8'h11}) begin
      errs++;
      $display("FAIL to_drain0: valid,last,data got %b,%b,%h want 1,0,11", o_valid, o_last, o_data);
    end
    tick();
    vecs++;
    if ({o_valid, o_last, o_data} !== {2'b11, 8'h22}) begin
      errs++;
      $display("FAIL to_drain1: valid,last,data got %b,%b,%h want 1,1,22", o_valid, o_last, o_data);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    send(8'hA5); send(8'h03); send(8'h11);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    vecs++;
    if ({o_valid, o_last, o_busy, o_err_len, o_err_checksum, o_err_timeout, o_drop} !== 7'd0) begin
      errs++;
      $display("FAIL rst_mid: got %b want 0", {o_valid, o_last, o_busy, o_err_len, o_err_checksum, o_err_timeout, o_drop});
    end
    send(8'h22); send(8'h33); send(8'h97);
    repeat (T + 2) tick();
    vecs++;
    if ({o_valid, o_busy, o_err_timeout, o_err_checksum} !== 4'd0) begin
      errs++;
      $display("FAIL rst_hunt: got %b want 0000", {o_valid, o_busy, o_err_timeout, o_err_checksum});
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_checksum();
    test_length();
    test_hunt();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
